// File: rtl/hazard_ctrl_param_pkg.sv
// Shared encodings for the parametrised hazard controller.
// Optional perf counters in the top are enabled by HAZARD_PERF_CNT_EN.
package hazard_ctrl_param_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    typedef enum logic {
        DM_IDLE = 1'b0,
        DM_BUSY = 1'b1
    } dm_state_e;

endpackage

// File: rtl/hazard_fwd_mux_sel.sv
// Forwarding select for one source operand; the youngest matching writer wins.
module hazard_fwd_mux_sel
    import hazard_ctrl_param_pkg::*;
(
    input  logic       ex_hit,
    input  logic       mem_hit,
    input  logic       wb_hit,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (ex_hit) begin
            sel = FWD_EX;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_param.sv
// Hazard controller: operand forwarding, load-use bubble, data/instruction memory wait handling.
// Define HAZARD_PERF_CNT_EN to add saturating perf counters for freeze, ld_bubble and if_stall.
//
// Data-memory FSM:
//   state   | meaning
//   DM_IDLE | no outstanding data access; a request without done starts a wait
//   DM_BUSY | waiting for mem_done; counts busy cycles toward the timeout
module hazard_ctrl_param
    import hazard_ctrl_param_pkg::*;
#(
    parameter int REG_AW  = 3,
    parameter int NUM_SRC = 2,
    parameter int R0_ZERO = 0,
    parameter int TMO_W   = 6,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_v,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic [REG_AW-1:0]         mem_rd,
    input  logic [REG_AW-1:0]         wb_rd,
    input  logic                      ex_rd_v,
    input  logic                      mem_rd_v,
    input  logic                      wb_rd_v,
    input  logic                      ex_is_load,
    input  logic                      mem_req,
    input  logic                      mem_done,
    input  logic                      imem_done,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      freeze,
    output logic                      if_stall,
    output logic                      ld_bubble,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]          perf_freeze,
    output logic [CNT_W-1:0]          perf_ldb,
    output logic [CNT_W-1:0]          perf_ifs,
`endif
    output logic                      mem_tmo
);

    if (NUM_SRC < 1 || NUM_SRC > 4) begin : g_bad_num_src
        $error("hazard_ctrl_param: NUM_SRC must be 1..4");
    end
    if (TMO_W < 2) begin : g_bad_tmo_w
        $error("hazard_ctrl_param: TMO_W must be at least 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("hazard_ctrl_param: CNT_W must be at least 1");
    end

    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    // Last busy count before the counter would reach all-ones.
    localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_ONE;

    logic [NUM_SRC-1:0] ex_hit;
    logic [NUM_SRC-1:0] mem_hit;
    logic [NUM_SRC-1:0] wb_hit;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_AW-1:0] src;
        logic              src_live;

        assign src      = id_src[i*REG_AW +: REG_AW];
        assign src_live = id_src_v[i] & ~((R0_ZERO != 0) && (src == '0));

        assign ex_hit[i]  = src_live & ex_rd_v  & (ex_rd  == src);
        assign mem_hit[i] = src_live & mem_rd_v & (mem_rd == src);
        assign wb_hit[i]  = src_live & wb_rd_v  & (wb_rd  == src);

        hazard_fwd_mux_sel u_fwd_mux_sel (
            .ex_hit  (ex_hit[i]),
            .mem_hit (mem_hit[i]),
            .wb_hit  (wb_hit[i]),
            .sel     (fwd_sel[2*i +: 2])
        );
    end

    dm_state_e        dm_state;
    dm_state_e        dm_next;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_cnt_next;
    logic             tmo_hit;
    logic             freeze_raw;
    logic             load_use;
    logic             imem_done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dm_state    <= DM_IDLE;
            tmo_cnt     <= '0;
            imem_done_q <= 1'b0;
        end else begin
            dm_state    <= dm_next;
            tmo_cnt     <= tmo_cnt_next;
            imem_done_q <= imem_done;
        end
    end

    always_comb begin
        dm_next      = dm_state;
        tmo_cnt_next = tmo_cnt;
        tmo_hit      = 1'b0;
        freeze_raw   = 1'b0;
        case (dm_state)
            DM_IDLE: begin
                // A request answered in the same cycle needs no wait state.
                if (mem_req && !mem_done) begin
                    freeze_raw   = 1'b1;
                    dm_next      = DM_BUSY;
                    tmo_cnt_next = '0;
                end
            end
            DM_BUSY: begin
                if (mem_done) begin
                    dm_next = DM_IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    dm_next = DM_IDLE;
                end else begin
                    freeze_raw   = 1'b1;
                    tmo_cnt_next = tmo_cnt + TMO_ONE;
                end
            end
            default: begin
                dm_next = DM_IDLE;
            end
        endcase
    end

    assign load_use = ex_is_load & ex_rd_v & (|ex_hit);

    // Controls are held low while reset is asserted, independent of the inputs.
    assign freeze    = rst & freeze_raw;
    assign mem_tmo   = rst & tmo_hit;
    assign ld_bubble = rst & load_use & ~freeze_raw;
    assign if_stall  = rst & ~imem_done & ~imem_done_q & ~freeze_raw & ~load_use;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        logic [CNT_W-1:0] r;
        r = v;
        if (en && (v != CNT_MAX)) begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_freeze <= '0;
            perf_ldb    <= '0;
            perf_ifs    <= '0;
        end else begin
            perf_freeze <= sat_inc(perf_freeze, freeze);
            perf_ldb    <= sat_inc(perf_ldb, ld_bubble);
            perf_ifs    <= sat_inc(perf_ifs, if_stall);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Self-checking bench for hazard_ctrl_param: directed pins plus randomized traffic against a behavioural model.
// Inputs change 1 time unit after a rising edge; outputs are checked on the falling edge.
module tb_hazard_ctrl_param;

    localparam int REG_AW    = 3;
    localparam int NUM_SRC   = 2;
    localparam int R0_ZERO   = 1;
    localparam int TMO_W     = 3;
    localparam int CNT_W     = 8;
    localparam int SRC_W     = NUM_SRC * REG_AW;
    localparam int TMO_LIMIT = (1 << TMO_W) - 1;
    localparam int CNT_SAT   = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [SRC_W-1:0]     id_src;
    logic [NUM_SRC-1:0]   id_src_v;
    logic [REG_AW-1:0]    ex_rd, mem_rd, wb_rd;
    logic                 ex_rd_v, mem_rd_v, wb_rd_v;
    logic                 ex_is_load, mem_req, mem_done, imem_done;
    logic [2*NUM_SRC-1:0] fwd_sel;
    logic                 freeze, if_stall, ld_bubble, mem_tmo;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0]     perf_freeze, perf_ldb, perf_ifs;
`endif

    hazard_ctrl_param #(
        .REG_AW  (REG_AW),
        .NUM_SRC (NUM_SRC),
        .R0_ZERO (R0_ZERO),
        .TMO_W   (TMO_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_src     (id_src),
        .id_src_v   (id_src_v),
        .ex_rd      (ex_rd),
        .mem_rd     (mem_rd),
        .wb_rd      (wb_rd),
        .ex_rd_v    (ex_rd_v),
        .mem_rd_v   (mem_rd_v),
        .wb_rd_v    (wb_rd_v),
        .ex_is_load (ex_is_load),
        .mem_req    (mem_req),
        .mem_done   (mem_done),
        .imem_done  (imem_done),
        .fwd_sel    (fwd_sel),
        .freeze     (freeze),
        .if_stall   (if_stall),
        .ld_bubble  (ld_bubble),
`ifdef HAZARD_PERF_CNT_EN
        .perf_freeze(perf_freeze),
        .perf_ldb   (perf_ldb),
        .perf_ifs   (perf_ifs),
`endif
        .mem_tmo    (mem_tmo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: a wait is "open" from the first frozen cycle; it may hold
    // the pipeline for at most TMO_LIMIT cycles, after which the timeout fires.
    bit                   m_wait    = 1'b0;
    int                   m_waited  = 0;
    bit                   m_imem_q  = 1'b0;
    int                   m_pf = 0, m_pl = 0, m_pi = 0;
    logic [2*NUM_SRC-1:0] e_fwd;
    bit                   e_ex_hit, e_freeze, e_ldb, e_ifs, e_tmo;
    bit                   n_wait;
    int                   n_waited;
    logic [REG_AW-1:0]    s;
    bit                   live;
    logic [1:0]           code;

    always @(negedge clk) begin
        if (!rst) begin
            m_wait = 1'b0; m_waited = 0; m_imem_q = 1'b0;
            m_pf = 0; m_pl = 0; m_pi = 0;
        end
        e_fwd    = '0;
        e_ex_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s    = id_src[i*REG_AW +: REG_AW];
            live = id_src_v[i] && !(R0_ZERO != 0 && s == '0);
            code = 2'b00;
            if (live && wb_rd_v  && wb_rd  == s) code = 2'b11;
            if (live && mem_rd_v && mem_rd == s) code = 2'b10;
            if (live && ex_rd_v  && ex_rd  == s) begin
                code     = 2'b01;
                e_ex_hit = 1'b1;
            end
            e_fwd[2*i +: 2] = code;
        end
        e_freeze = 1'b0; e_tmo = 1'b0; e_ldb = 1'b0; e_ifs = 1'b0;
        n_wait   = m_wait; n_waited = m_waited;
        if (rst) begin
            if (!m_wait) begin
                if (mem_req && !mem_done) begin
                    e_freeze = 1'b1; n_wait = 1'b1; n_waited = 1;
                end
            end else if (mem_done) begin
                n_wait = 1'b0;
            end else if (m_waited == TMO_LIMIT) begin
                e_tmo = 1'b1; n_wait = 1'b0;
            end else begin
                e_freeze = 1'b1; n_waited = m_waited + 1;
            end
            e_ldb = ex_is_load && e_ex_hit && !e_freeze;
            e_ifs = !imem_done && !m_imem_q && !e_freeze && !e_ldb;
        end
        chk("m_fwd_sel",   32'(fwd_sel),   32'(e_fwd));
        chk("m_freeze",    32'(freeze),    32'(e_freeze));
        chk("m_mem_tmo",   32'(mem_tmo),   32'(e_tmo));
        chk("m_ld_bubble", 32'(ld_bubble), 32'(e_ldb));
        chk("m_if_stall",  32'(if_stall),  32'(e_ifs));
`ifdef HAZARD_PERF_CNT_EN
        chk("m_perf_freeze", 32'(perf_freeze), 32'(m_pf));
        chk("m_perf_ldb",    32'(perf_ldb),    32'(m_pl));
        chk("m_perf_ifs",    32'(perf_ifs),    32'(m_pi));
`endif
        if (rst) begin
            m_wait   = n_wait;
            m_waited = n_waited;
            m_imem_q = imem_done;
            if (e_freeze && m_pf < CNT_SAT) m_pf++;
            if (e_ldb    && m_pl < CNT_SAT) m_pl++;
            if (e_ifs    && m_pi < CNT_SAT) m_pi++;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic clear();
        id_src = '0; id_src_v = '0;
        ex_rd = '0; mem_rd = '0; wb_rd = '0;
        ex_rd_v = 1'b0; mem_rd_v = 1'b0; wb_rd_v = 1'b0;
        ex_is_load = 1'b0; mem_req = 1'b0; mem_done = 1'b0;
        imem_done = 1'b1;
    endtask

    initial begin
        // Reset with inputs that would otherwise raise every control output.
        rst = 1'b0;
        clear();
        imem_done = 1'b0; mem_req = 1'b1;
        id_src = {3'd5, 3'd2}; id_src_v = 2'b11; ex_rd = 3'd5; ex_rd_v = 1'b1; ex_is_load = 1'b1;
        #3;
        chk("rst_freeze",    32'(freeze),    32'd0);
        chk("rst_if_stall",  32'(if_stall),  32'd0);
        chk("rst_ld_bubble", 32'(ld_bubble), 32'd0);
        chk("rst_mem_tmo",   32'(mem_tmo),   32'd0);
        @(posedge clk);
        nxt();
        rst = 1'b1;
        clear();

        // Forwarding priority.
        id_src = {3'd3, 3'd3}; id_src_v = 2'b11;
        ex_rd = 3'd3; mem_rd = 3'd3; wb_rd = 3'd3;
        ex_rd_v = 1'b1; mem_rd_v = 1'b1; wb_rd_v = 1'b1;
        neg(); chk("fwd_all_ex", 32'(fwd_sel), 32'h5);
        nxt(); ex_rd_v = 1'b0;
        neg(); chk("fwd_no_ex", 32'(fwd_sel), 32'hA);

        // Register 0 is never forwarded nor hazard-checked.
        nxt(); clear();
        id_src = {3'd0, 3'd0}; id_src_v = 2'b01; ex_rd = 3'd0; ex_rd_v = 1'b1; ex_is_load = 1'b1;
        neg();
        chk("r0_fwd", 32'(fwd_sel[1:0]), 32'd0);
        chk("r0_ldb", 32'(ld_bubble),    32'd0);

        // Load-use bubble, then MEM forwarding.
        nxt(); clear();
        id_src = {3'd5, 3'd2}; id_src_v = 2'b11; ex_rd = 3'd5; ex_rd_v = 1'b1; ex_is_load = 1'b1;
        neg();
        chk("lu_ldb", 32'(ld_bubble), 32'd1);
        chk("lu_fwd", 32'(fwd_sel),   32'h4);
        nxt(); ex_is_load = 1'b0; ex_rd_v = 1'b0; mem_rd = 3'd5; mem_rd_v = 1'b1;
        neg();
        chk("lu_next_fwd", 32'(fwd_sel[3:2]), 32'h2);
        chk("lu_next_ldb", 32'(ld_bubble),    32'd0);

        // Data wait of 4 cycles with a load-use pending.
        nxt(); clear();
        id_src = {3'd5, 3'd2}; id_src_v = 2'b11; ex_rd = 3'd5; ex_rd_v = 1'b1; ex_is_load = 1'b1;
        mem_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            neg();
            chk("dw_freeze", 32'(freeze),    32'd1);
            chk("dw_ldb",    32'(ld_bubble), 32'd0);
            nxt();
        end
        mem_done = 1'b1;
        neg();
        chk("dw_done_freeze", 32'(freeze),    32'd0);
        chk("dw_done_ldb",    32'(ld_bubble), 32'd1);

        // Timeout: seven frozen cycles, then a single mem_tmo pulse.
        nxt(); clear(); mem_req = 1'b1;
        for (int k = 0; k < 7; k++) begin
            neg();
            chk("to_freeze", 32'(freeze),  32'd1);
            chk("to_tmo",    32'(mem_tmo), 32'd0);
            nxt();
        end
        neg();
        chk("to_hit_freeze", 32'(freeze),  32'd0);
        chk("to_hit_tmo",    32'(mem_tmo), 32'd1);
        nxt(); mem_req = 1'b0;
        neg();
        chk("to_after_tmo", 32'(mem_tmo), 32'd0);

        // Asynchronous reset in the middle of a wait.
        nxt(); mem_req = 1'b1;
        neg();
        nxt();
        #2; rst = 1'b0;
        #1; chk("rst_mid_freeze", 32'(freeze), 32'd0);
        mem_req = 1'b0; mem_done = 1'b1;
        nxt(); rst = 1'b1;
        neg();
        chk("rst_stale_done_freeze", 32'(freeze),  32'd0);
        chk("rst_stale_done_tmo",    32'(mem_tmo), 32'd0);
        nxt(); mem_done = 1'b0; mem_req = 1'b1;
        neg(); chk("rst_new_req_freeze", 32'(freeze), 32'd1);
        nxt(); mem_done = 1'b1;
        nxt(); clear();

        // Fetch stall grace window.
        imem_done = 1'b0;
        neg();
        nxt();
        neg(); chk("if_stall_idle", 32'(if_stall), 32'd1);
        nxt(); imem_done = 1'b1;
        neg(); chk("if_stall_t0", 32'(if_stall), 32'd0);
        nxt(); imem_done = 1'b0;
        neg(); chk("if_stall_t1", 32'(if_stall), 32'd0);
        nxt();
        neg(); chk("if_stall_t2", 32'(if_stall), 32'd1);

        // Randomized traffic; reset only changes just after a rising edge.
        for (int c = 0; c < 3000; c++) begin
            nxt();
            rst        = ($urandom_range(0, 99) != 0);
            id_src     = SRC_W'($urandom);
            id_src_v   = NUM_SRC'($urandom);
            ex_rd      = REG_AW'($urandom);
            mem_rd     = REG_AW'($urandom);
            wb_rd      = REG_AW'($urandom);
            ex_rd_v    = ($urandom_range(0, 3) != 0);
            mem_rd_v   = ($urandom_range(0, 3) != 0);
            wb_rd_v    = ($urandom_range(0, 3) != 0);
            ex_is_load = ($urandom_range(0, 9) < 3);
            mem_req    = ($urandom_range(0, 9) < 4);
            mem_done   = ($urandom_range(0, 3) == 0);
            imem_done  = ($urandom_range(0, 1) == 0);
        end
        nxt();
        rst = 1'b1;
        clear();
        neg();
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
